// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg
// Purpose : shared definitions for the sequential EX-stage ALU (alu_seq) and
//           its iterative multiply/divide engine (alu_seq_iter).
// Contents: op_e      - 4-bit operation codes
//           state_e   - control FSM states
//           ITER_MODE_* - engine mode selectors
//           is_multicycle() - which ops are handed to the iterative engine
// Build   : macro ALU_SEQ_DIV_EN enables the divider; when it is undefined
//           DIV is not treated as a multi-cycle op.
// ---------------------------------------------------------------------------
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_ANDN = 4'd5,
        OP_ROL  = 4'd6,
        OP_SLL  = 4'd7,
        OP_ROR  = 4'd8,
        OP_SRL  = 4'd9,
        OP_SRA  = 4'd10,
        OP_SEQ  = 4'd11,
        OP_SLT  = 4'd12,
        OP_SLE  = 4'd13,
        OP_MUL  = 4'd14,
        OP_DIV  = 4'd15
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic ITER_MODE_MUL = 1'b0;
    localparam logic ITER_MODE_DIV = 1'b1;

    // Ops that occupy the iterative engine. Divide-by-zero is still a DIV
    // here; the top short-circuits it separately.
    function automatic logic is_multicycle(input op_e op);
`ifdef ALU_SEQ_DIV_EN
        return (op == OP_MUL) || (op == OP_DIV);
`else
        return (op == OP_MUL);
`endif
    endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// ---------------------------------------------------------------------------
// alu_seq_iter
// Purpose : iterative engine shared by MUL (shift-add) and DIV (restoring).
//           Works on unsigned magnitudes; sign handling lives in alu_seq.
//           Takes exactly WIDTH steps after i_start.
// Ports   : i_clk, i_rst  - clock, synchronous active-high reset
//           i_start       - load operands and begin (one-cycle pulse)
//           i_mode        - ITER_MODE_MUL / ITER_MODE_DIV (only with
//                           ALU_SEQ_DIV_EN defined)
//           i_magA/i_magB - magnitudes: multiplicand/multiplier or
//                           dividend/divisor
//           o_done        - high during the final step
//           o_hi/o_lo     - value produced by the current step; on o_done
//                           this is {product} or {remainder, quotient}
// Build   : macro ALU_SEQ_DIV_EN adds the restoring-divide datapath.
// ---------------------------------------------------------------------------
module alu_seq_iter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
`ifdef ALU_SEQ_DIV_EN
    input  logic             i_mode,
`endif
    input  logic [WIDTH-1:0] i_magA,
    input  logic [WIDTH-1:0] i_magB,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CNT_W = $clog2(WIDTH);

    logic             r_busy;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_operand;
    logic [WIDTH:0]   w_mulSum;
    logic [WIDTH-1:0] w_nextHi;
    logic [WIDTH-1:0] w_nextLo;
`ifdef ALU_SEQ_DIV_EN
    logic             r_mode;
    logic [WIDTH:0]   w_rem;
    logic [WIDTH:0]   w_diff;
`endif

    // One step of the algorithm. For MUL the multiplier sits in r_lo and is
    // consumed LSB first while partial sums shift into r_hi. For DIV the
    // dividend shifts out of r_lo into the partial remainder in r_hi, and
    // quotient bits shift into r_lo from the right. The remainder always
    // stays below the divisor, so the (WIDTH+1)-bit difference's MSB is a
    // clean borrow flag.
    always_comb begin
        w_mulSum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_operand} : {(WIDTH+1){1'b0}});
        w_nextHi = w_mulSum[WIDTH:1];
        w_nextLo = {w_mulSum[0], r_lo[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
        w_rem  = {r_hi, r_lo[WIDTH-1]};
        w_diff = w_rem - {1'b0, r_operand};
        if (r_mode == ITER_MODE_DIV) begin
            if (!w_diff[WIDTH]) begin
                w_nextHi = w_diff[WIDTH-1:0];
                w_nextLo = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_nextHi = w_rem[WIDTH-1:0];
                w_nextLo = {r_lo[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    assign o_done = r_busy && (r_count == CNT_W'(WIDTH-1));
    assign o_hi   = w_nextHi;
    assign o_lo   = w_nextLo;

    // Operand load on start, then one step per clock until the last one.
    // The caller samples o_hi/o_lo during the final step, so the registers
    // themselves never need to hold the finished answer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy    <= 1'b0;
            r_count   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_operand <= '0;
`ifdef ALU_SEQ_DIV_EN
            r_mode    <= ITER_MODE_MUL;
`endif
        end else if (i_start) begin
            r_busy    <= 1'b1;
            r_count   <= '0;
            r_hi      <= '0;
`ifdef ALU_SEQ_DIV_EN
            r_mode    <= i_mode;
            r_lo      <= (i_mode == ITER_MODE_DIV) ? i_magA : i_magB;
            r_operand <= (i_mode == ITER_MODE_DIV) ? i_magB : i_magA;
`else
            r_lo      <= i_magB;
            r_operand <= i_magA;
`endif
        end else if (r_busy) begin
            r_hi    <= w_nextHi;
            r_lo    <= w_nextLo;
            r_count <= r_count + 1'b1;
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Purpose : registered, width-generic EX-stage ALU with valid/ready on both
//           sides. Single-cycle ops finish one cycle after accept; MUL and
//           DIV run WIDTH cycles in alu_seq_iter and finish WIDTH+1 cycles
//           after accept.
// Ports   : clk, rst            - clock, synchronous active-high reset
//           in_valid/in_ready   - operand handshake (ready only in IDLE)
//           A, B, Op, sign      - operands, op code, signed interpretation
//           out_valid/out_ready - result handshake (held until taken)
//           ALU_out             - result
//           Ofl, Dz, Ill        - overflow, divide-by-zero, illegal op
// Build   : macro ALU_SEQ_DIV_EN builds the divider. Without it Op 15
//           completes in one cycle with Ill=1 and ALU_out=0.
// ---------------------------------------------------------------------------
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Op,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_out,
    output logic             Ofl,
    output logic             Dz,
    output logic             Ill
);

    state_e             r_state;
    state_e             w_nextState;
    logic [WIDTH-1:0]   r_aluOut;
    logic               r_ofl;
    logic               r_dz;
    logic               r_ill;
    logic               r_sign;
    logic               r_neg;

    op_e                w_op;
    logic               w_accept;
    logic               w_divByZero;
    logic               w_iterOp;
    logic               w_startIter;
    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH-1:0]   w_magA;
    logic [WIDTH-1:0]   w_magB;

    logic [WIDTH:0]     w_addSum;
    logic [WIDTH:0]     w_subDiff;
    logic [2*WIDTH-1:0] w_rotL;
    logic [2*WIDTH-1:0] w_rotR;
    logic               w_lt;
    logic               w_le;
    logic [WIDTH-1:0]   w_scResult;
    logic               w_scOfl;
    logic               w_scDz;
    logic               w_scIll;

    logic               w_iterDone;
    logic [WIDTH-1:0]   w_iterHi;
    logic [WIDTH-1:0]   w_iterLo;
    logic [2*WIDTH-1:0] w_product;
    logic [2*WIDTH-1:0] w_prodSigned;
    logic [WIDTH:0]     w_prodTop;
    logic               w_mulOfl;
`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH-1:0]   w_quot;
    logic               w_divOfl;
`endif

    assign w_op        = op_e'(Op);
    assign in_ready    = (r_state == ST_IDLE);
    assign out_valid   = (r_state == ST_DONE);
    assign w_accept    = in_valid && in_ready;
    assign w_divByZero = (B == '0);
    assign w_iterOp    = is_multicycle(w_op) && !((w_op == OP_DIV) && w_divByZero);
    assign w_startIter = w_accept && w_iterOp;
    assign w_shamt     = B[SHAMT_W-1:0];

    // Negating the most negative value gives back the same bit pattern,
    // which read unsigned is exactly its magnitude, so no special case.
    assign w_magA = (sign && A[WIDTH-1]) ? -A : A;
    assign w_magB = (sign && B[WIDTH-1]) ? -B : B;

    assign w_addSum  = {1'b0, A} + {1'b0, B};
    assign w_subDiff = {1'b0, B} - {1'b0, A};
    assign w_rotL    = {A, A} << w_shamt;
    assign w_rotR    = {A, A} >> w_shamt;
    assign w_lt      = sign ? ($signed(A) <  $signed(B)) : (A <  B);
    assign w_le      = sign ? ($signed(A) <= $signed(B)) : (A <= B);

    // Everything that finishes in one cycle. Rotates come from shifting a
    // doubled copy of A so a zero shift needs no special case. Divide by
    // zero lands here too because it never enters the engine.
    always_comb begin
        w_scResult = '0;
        w_scOfl    = 1'b0;
        w_scDz     = 1'b0;
        w_scIll    = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_scResult = w_addSum[WIDTH-1:0];
                w_scOfl    = sign ? ((A[WIDTH-1] == B[WIDTH-1]) && (w_addSum[WIDTH-1] != A[WIDTH-1]))
                                  : w_addSum[WIDTH];
            end
            OP_SUB: begin
                w_scResult = w_subDiff[WIDTH-1:0];
                w_scOfl    = sign ? ((B[WIDTH-1] != A[WIDTH-1]) && (w_subDiff[WIDTH-1] != B[WIDTH-1]))
                                  : w_subDiff[WIDTH];
            end
            OP_AND:  w_scResult = A & B;
            OP_OR:   w_scResult = A | B;
            OP_XOR:  w_scResult = A ^ B;
            OP_ANDN: w_scResult = A & ~B;
            OP_ROL:  w_scResult = w_rotL[2*WIDTH-1:WIDTH];
            OP_SLL:  w_scResult = A << w_shamt;
            OP_ROR:  w_scResult = w_rotR[WIDTH-1:0];
            OP_SRL:  w_scResult = A >> w_shamt;
            OP_SRA:  w_scResult = $signed(A) >>> w_shamt;
            OP_SEQ:  w_scResult = WIDTH'(A == B);
            OP_SLT:  w_scResult = WIDTH'(w_lt);
            OP_SLE:  w_scResult = WIDTH'(w_le);
            OP_DIV: begin
`ifdef ALU_SEQ_DIV_EN
                w_scResult = '1;
                w_scDz     = 1'b1;
`else
                w_scIll    = 1'b1;
`endif
            end
            default: w_scResult = '0;
        endcase
    end

    alu_seq_iter #(
        .WIDTH   (WIDTH)
    ) u_iter (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (w_startIter),
`ifdef ALU_SEQ_DIV_EN
        .i_mode  ((w_op == OP_DIV) ? ITER_MODE_DIV : ITER_MODE_MUL),
`endif
        .i_magA  (w_magA),
        .i_magB  (w_magB),
        .o_done  (w_iterDone),
        .o_hi    (w_iterHi),
        .o_lo    (w_iterLo)
    );

    // Sign fix-up applied during the engine's final step. A signed product
    // fits when its top WIDTH+1 bits are all equal; an unsigned one fits
    // when the high half is zero.
    assign w_product    = {w_iterHi, w_iterLo};
    assign w_prodSigned = r_neg ? -w_product : w_product;
    assign w_prodTop    = w_prodSigned[2*WIDTH-1:WIDTH-1];
    assign w_mulOfl     = r_sign ? !((w_prodTop == '0) || (&w_prodTop)) : (|w_iterHi);

`ifdef ALU_SEQ_DIV_EN
    // A positive signed quotient with its MSB set can only be MIN / -1;
    // leaving it un-negated yields MIN, which is the wanted wrapped result.
    assign w_quot   = r_neg ? -w_iterLo : w_iterLo;
    assign w_divOfl = r_sign && !r_neg && w_iterLo[WIDTH-1];
`endif

    // Control FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. IDLE is the only state that accepts, so the DONE
    // cycle always separates two transactions.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (w_iterOp) begin
                        w_nextState = (w_op == OP_MUL) ? ST_MUL : ST_DIV;
                    end else begin
                        w_nextState = ST_DONE;
                    end
                end
            end
            ST_MUL,
            ST_DIV: begin
                if (w_iterDone) begin
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Result registers. Single-cycle results are captured on accept;
    // engine results on its last step. Nothing else writes them, so they
    // stay stable for as long as DONE is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_aluOut <= '0;
            r_ofl    <= 1'b0;
            r_dz     <= 1'b0;
            r_ill    <= 1'b0;
            r_sign   <= 1'b0;
            r_neg    <= 1'b0;
        end else if (w_accept) begin
            r_sign <= sign;
            r_neg  <= sign && (A[WIDTH-1] ^ B[WIDTH-1]);
            if (!w_iterOp) begin
                r_aluOut <= w_scResult;
                r_ofl    <= w_scOfl;
                r_dz     <= w_scDz;
                r_ill    <= w_scIll;
            end
        end else if ((r_state == ST_MUL) && w_iterDone) begin
            r_aluOut <= w_prodSigned[WIDTH-1:0];
            r_ofl    <= w_mulOfl;
            r_dz     <= 1'b0;
            r_ill    <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
        end else if ((r_state == ST_DIV) && w_iterDone) begin
            r_aluOut <= w_quot;
            r_ofl    <= w_divOfl;
            r_dz     <= 1'b0;
            r_ill    <= 1'b0;
`endif
        end
    end

    assign ALU_out = r_aluOut;
    assign Ofl     = r_ofl;
    assign Dz      = r_dz;
    assign Ill     = r_ill;

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
// Purpose : self-checking bench for alu_seq at WIDTH=16. Expected values come
//           from an integer-arithmetic reference model of the op semantics.
// Build   : honours ALU_SEQ_DIV_EN so DIV expectations match the build.
// ---------------------------------------------------------------------------
module tb_alu_seq;

    localparam int W = 16;

`ifdef ALU_SEQ_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [3:0]   Op;
    logic         sign;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] ALU_out;
    logic         Ofl;
    logic         Dz;
    logic         Ill;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int op;
        int a;
        int b;
        bit sgn;
        int res;
        bit ofl;
        bit dz;
        bit ill;
        int lat;
    } vec_t;

    always #5 clk = ~clk;

    alu_seq #(
        .WIDTH     (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Op        (Op),
        .sign      (sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALU_out   (ALU_out),
        .Ofl       (Ofl),
        .Dz        (Dz),
        .Ill       (Ill)
    );

    // Safety net so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired got timeout want finish");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int toSigned(input int v);
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    function automatic bit fits(input longint v, input bit sgn);
        if (sgn) return (v >= -32768) && (v <= 32767);
        return (v >= 0) && (v <= 65535);
    endfunction

    // Reference model: plain integer arithmetic over the op definitions.
    task automatic refModel(input int op, input int a, input int b, input bit sgn,
                            output int res, output bit ofl, output bit dz,
                            output bit ill, output int lat);
        int     sa;
        int     sb;
        int     sh;
        int     q;
        longint p;
        sa  = sgn ? toSigned(a) : a;
        sb  = sgn ? toSigned(b) : b;
        sh  = b % 16;
        res = 0;
        ofl = 0;
        dz  = 0;
        ill = 0;
        lat = 1;
        case (op)
            0:  begin res = (sa + sb) & 'hFFFF; ofl = !fits(longint'(sa + sb), sgn); end
            1:  begin res = (sb - sa) & 'hFFFF; ofl = !fits(longint'(sb - sa), sgn); end
            2:  res = a & b;
            3:  res = a | b;
            4:  res = a ^ b;
            5:  res = a & ~b & 'hFFFF;
            6:  res = ((a << sh) | (a >> (16 - sh))) & 'hFFFF;
            7:  res = (a << sh) & 'hFFFF;
            8:  res = ((a >> sh) | (a << (16 - sh))) & 'hFFFF;
            9:  res = a >> sh;
            10: res = (toSigned(a) >>> sh) & 'hFFFF;
            11: res = (a == b) ? 1 : 0;
            12: res = (sa < sb) ? 1 : 0;
            13: res = (sa <= sb) ? 1 : 0;
            14: begin
                p   = longint'(sa) * longint'(sb);
                res = int'(p & 64'hFFFF);
                ofl = !fits(p, sgn);
                lat = 17;
            end
            default: begin
                if (!DIV_EN) begin
                    ill = 1;
                end else if (b == 0) begin
                    res = 'hFFFF;
                    dz  = 1;
                end else begin
                    q   = sa / sb;
                    res = q & 'hFFFF;
                    ofl = !fits(longint'(q), sgn);
                    lat = 17;
                end
            end
        endcase
    endtask

    // Presents one op at a negedge while IDLE, then counts cycles to
    // out_valid; lat stays -1 on timeout. Also counts cycles where in_ready
    // was seen high before the result appeared.
    task automatic applyStimulus(input int op, input int a, input int b, input bit sgn,
                                 output int lat, output int readyHigh);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1;
        Op       = op[3:0];
        A        = a[W-1:0];
        B        = b[W-1:0];
        sign     = sgn;
        @(posedge clk);
        lat       = -1;
        readyHigh = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            A        = W'($urandom);
            B        = W'($urandom);
            if (out_valid) begin
                lat = c;
                break;
            end
            if (in_ready) readyHigh++;
        end
    endtask

    task automatic releaseResult();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        Op        = '0;
        sign      = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (ALU_out !== 16'h0000) begin errors++; $display("[TB] FAIL reset_alu_out got %h want 0000", ALU_out); end
        checks++; if ({Ofl, Dz, Ill} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags got %b want 000", {Ofl, Dz, Ill}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        vec_t vecs[$];
        int   lat;
        int   rdy;
        vecs.push_back('{0,  'h7FFF, 'h0001, 1'b1, 'h8000, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{0,  'h7FFF, 'h0001, 1'b0, 'h8000, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{1,  'h0005, 'h0003, 1'b0, 'hFFFE, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{14, 'hFFFD, 'h0007, 1'b1, 'hFFEB, 1'b0, 1'b0, 1'b0, 17});
        vecs.push_back('{14, 'h0100, 'h0100, 1'b1, 'h0000, 1'b1, 1'b0, 1'b0, 17});
        vecs.push_back('{8,  'h8001, 'h0011, 1'b0, 'hC000, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{10, 'h8000, 'h0004, 1'b0, 'hF800, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{6,  'h8001, 'h0000, 1'b0, 'h8001, 1'b0, 1'b0, 1'b0, 1});
`ifdef ALU_SEQ_DIV_EN
        vecs.push_back('{15, 'hFFF9, 'h0002, 1'b1, 'hFFFD, 1'b0, 1'b0, 1'b0, 17});
        vecs.push_back('{15, 'h1234, 'h0000, 1'b1, 'hFFFF, 1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{15, 'h8000, 'hFFFF, 1'b1, 'h8000, 1'b1, 1'b0, 1'b0, 17});
`else
        vecs.push_back('{15, 'hFFF9, 'h0002, 1'b1, 'h0000, 1'b0, 1'b0, 1'b1, 1});
        vecs.push_back('{15, 'h1234, 'h0000, 1'b1, 'h0000, 1'b0, 1'b0, 1'b1, 1});
`endif
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sgn, lat, rdy);
            checks++; if (lat !== vecs[i].lat) begin errors++; $display("[TB] FAIL dir%0d_latency got %0d want %0d", i, lat, vecs[i].lat); end
            checks++; if (rdy !== 0) begin errors++; $display("[TB] FAIL dir%0d_in_ready_busy got %0d want 0", i, rdy); end
            checks++; if (ALU_out !== vecs[i].res[W-1:0]) begin errors++; $display("[TB] FAIL dir%0d_result got %h want %h", i, ALU_out, vecs[i].res[W-1:0]); end
            checks++; if ({Ofl, Dz, Ill} !== {vecs[i].ofl, vecs[i].dz, vecs[i].ill}) begin
                errors++;
                $display("[TB] FAIL dir%0d_flags got %b want %b", i, {Ofl, Dz, Ill}, {vecs[i].ofl, vecs[i].dz, vecs[i].ill});
            end
            releaseResult();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int rdy;
        applyStimulus(0, 3, 4, 1'b0, lat, rdy);
        checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL bp_latency got %0d want 1", lat); end
        in_valid = 1'b1;
        Op       = 4'd4;
        A        = 16'hF0F0;
        B        = 16'h0FF0;
        sign     = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if ({out_valid, in_ready} !== 2'b10) begin errors++; $display("[TB] FAIL bp_hold%0d_handshake got %b want 10", c, {out_valid, in_ready}); end
            checks++; if (ALU_out !== 16'h0007) begin errors++; $display("[TB] FAIL bp_hold%0d_result got %h want 0007", c, ALU_out); end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("[TB] FAIL bp_release got %b want 01", {out_valid, in_ready}); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_next_valid got %b want 1", out_valid); end
        checks++; if (ALU_out !== 16'hFF00) begin errors++; $display("[TB] FAIL bp_next_result got %h want ff00", ALU_out); end
        releaseResult();
    endtask

    task automatic test_back_to_back();
        int expRes[$];
        bit expOfl[$];
        int accepts;
        int results;
        int op;
        int a;
        int b;
        bit sgn;
        int res;
        bit ofl;
        bit dz;
        bit ill;
        int lat;
        int er;
        bit eo;
        accepts   = 0;
        results   = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (out_valid) begin
                er = expRes.pop_front();
                eo = expOfl.pop_front();
                results++;
                checks++; if ({Ofl, ALU_out} !== {eo, er[W-1:0]}) begin
                    errors++;
                    $display("[TB] FAIL b2b_result%0d got %b/%h want %b/%h", results, Ofl, ALU_out, eo, er[W-1:0]);
                end
            end
            if (in_ready) begin
                op  = $urandom_range(0, 13);
                a   = $urandom_range(0, 65535);
                b   = $urandom_range(0, 65535);
                sgn = 1'($urandom_range(0, 1));
                refModel(op, a, b, sgn, res, ofl, dz, ill, lat);
                expRes.push_back(res);
                expOfl.push_back(ofl);
                in_valid = 1'b1;
                Op       = op[3:0];
                A        = a[W-1:0];
                B        = b[W-1:0];
                sign     = sgn;
                accepts++;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++; if (accepts !== 6) begin errors++; $display("[TB] FAIL b2b_accepts got %0d want 6", accepts); end
        checks++; if (results !== 6) begin errors++; $display("[TB] FAIL b2b_results got %0d want 6", results); end
        if (out_valid) releaseResult();
    endtask

    task automatic test_random();
        int op;
        int a;
        int b;
        bit sgn;
        int res;
        bit ofl;
        bit dz;
        bit ill;
        int expLat;
        int lat;
        int rdy;
        int edgeVals[5];
        edgeVals = '{0, 1, 'hFFFF, 'h8000, 'h7FFF};
        for (int n = 0; n < 80; n++) begin
            op  = $urandom_range(0, 15);
            a   = ($urandom_range(0, 3) == 0) ? edgeVals[$urandom_range(0, 4)] : $urandom_range(0, 65535);
            b   = ($urandom_range(0, 3) == 0) ? edgeVals[$urandom_range(0, 4)] : $urandom_range(0, 65535);
            sgn = 1'($urandom_range(0, 1));
            refModel(op, a, b, sgn, res, ofl, dz, ill, expLat);
            applyStimulus(op, a, b, sgn, lat, rdy);
            checks++; if (lat !== expLat) begin errors++; $display("[TB] FAIL rnd%0d_latency op %0d got %0d want %0d", n, op, lat, expLat); end
            checks++; if (ALU_out !== res[W-1:0]) begin
                errors++;
                $display("[TB] FAIL rnd%0d_result op %0d a %h b %h s %b got %h want %h", n, op, a, b, sgn, ALU_out, res[W-1:0]);
            end
            checks++; if ({Ofl, Dz, Ill} !== {ofl, dz, ill}) begin
                errors++;
                $display("[TB] FAIL rnd%0d_flags op %0d a %h b %h s %b got %b want %b", n, op, a, b, sgn, {Ofl, Dz, Ill}, {ofl, dz, ill});
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            checks++; if (ALU_out !== res[W-1:0]) begin errors++; $display("[TB] FAIL rnd%0d_hold got %h want %h", n, ALU_out, res[W-1:0]); end
            releaseResult();
        end
    endtask

    task automatic test_reset_mid_mul();
        int seen;
        int lat;
        int rdy;
        while (!in_ready) @(negedge clk);
        in_valid = 1'b1;
        Op       = 4'd14;
        A        = 16'h0123;
        B        = 16'h0045;
        sign     = 1'b0;
        @(posedge clk);
        repeat (7) @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("[TB] FAIL rst_mul_handshake got %b want 01", {out_valid, in_ready}); end
        checks++; if (ALU_out !== 16'h0000) begin errors++; $display("[TB] FAIL rst_mul_alu_out got %h want 0000", ALU_out); end
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL rst_mul_stale_result got %0d want 0", seen); end
        applyStimulus(0, 'h1111, 'h2222, 1'b0, lat, rdy);
        checks++; if ({lat, ALU_out} !== {32'sd1, 16'h3333}) begin errors++; $display("[TB] FAIL rst_mul_recover got %0d/%h want 1/3333", lat, ALU_out); end
        releaseResult();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
